shared_reg_arbiter: RTL

- Round-robin arbiter and sequencer for a single shared state register: N requesters compete to write one WIDTH-bit value.
- Grants at most one write per cycle and holds the value, its owner index, and a valid flag.
- Supports an optional ownership lock for multi-cycle exclusive access.
- Sits between producer pipelines and any consumer that reads one shared state word.

---
 rtl/shared_reg_arbiter_pkg.sv | 8 +
 rtl/shared_reg_arbiter_rr_arbiter.sv | 29 ++
 rtl/shared_reg_arbiter.sv | 75 +++++++
 3 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// shared_reg_pkg: lock states, owner-index width helper and size limits for shared_reg_arbiter.
package shared_reg_pkg;
   localparam int MAX_N = 16;
   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
   function automatic int owner_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/shared_reg_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, via a double-width masked priority encode.
module rr_arbiter
   import shared_reg_pkg::*;
#(
   parameter int N = 4,
   localparam int OW = owner_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [OW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [OW-1:0] grant_idx,
   output logic          any
);
   logic [N-1:0]   w_mask;
   logic [2*N-1:0] w_dbl;
   // Low half holds requests at or above ptr, so the lowest set bit is the round-robin winner.
   always_comb begin
      w_mask    = ~((N'(1) << ptr) - N'(1));
      w_dbl     = {req, req & w_mask};
      grant_idx = '0;
      any       = 1'b0;
      for (int k = 2*N-1; k >= 0; k--)
         if (w_dbl[k]) begin
            any       = 1'b1;
            grant_idx = OW'(k % N);
         end
      grant = any ? (N'(1) << grant_idx) : '0;
   end
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin writer arbitration with ownership lock for one shared register.
// Define SHARED_REG_PASSTHRU_EN for zero-latency pass-through of the winning write onto the outputs.
module shared_reg_arbiter
   import shared_reg_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N = 4,
   localparam int OW = owner_width(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic [N-1:0]     req_valid,
   input  logic [N-1:0]     req_lock,
   input  logic [N*WIDTH-1:0] req_data,
   output logic [N-1:0]     req_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic [OW-1:0]    owner,
   output logic             locked
);
   lock_state_t      r_state, w_state_nxt;
   logic [WIDTH-1:0] r_out, w_data;
   logic             r_valid, w_wr, w_arb_any;
   logic [OW-1:0]    r_owner, r_ptr, w_idx, w_arb_idx, w_ptr_nxt;
   logic [N-1:0]     w_arb_grant;

   rr_arbiter #(.N(N)) u_rr (
      .req       (req_valid),
      .ptr       (r_ptr),
      .grant     (w_arb_grant),
      .grant_idx (w_arb_idx),
      .any       (w_arb_any)
   );

   always_comb begin
      w_idx       = (r_state == LOCKED) ? r_owner : w_arb_idx;
      w_wr        = ~clr & ((r_state == LOCKED) ? req_valid[r_owner] : w_arb_any);
      req_ready   = w_wr ? (N'(1) << w_idx) : '0;
      w_data      = req_data[w_idx*WIDTH +: WIDTH];
      w_ptr_nxt   = (w_idx == OW'(N-1)) ? '0 : OW'(w_idx + 1'b1);
      w_state_nxt = clr ? UNLOCKED : w_wr ? (req_lock[w_idx] ? LOCKED : UNLOCKED) : r_state;
   end

   always_ff @(posedge clk)
      if (reset) begin
         r_state <= UNLOCKED;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_owner <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (clr) begin
            r_out   <= '0;
            r_valid <= 1'b0;
         end else if (w_wr) begin
            r_out   <= w_data;
            r_valid <= 1'b1;
            r_owner <= w_idx;
            if (r_state == UNLOCKED) r_ptr <= w_ptr_nxt;
         end
      end

   assign locked = (r_state == LOCKED);
`ifdef SHARED_REG_PASSTHRU_EN
   assign out       = clr ? '0 : w_wr ? w_data : r_out;
   assign out_valid = ~clr & (w_wr | r_valid);
   assign owner     = w_wr ? w_idx : r_owner;
`else
   assign out       = r_out;
   assign out_valid = r_valid;
   assign owner     = r_owner;
`endif
endmodule
